// File: rtl/aes_sched_pkg.sv
// rtl/aes_sched_pkg.sv - shared types and constants for the AES request scheduler
package aes_sched_pkg;

  localparam int AES_BLK_W = 128;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DRAIN  = 2'd2
  } sched_state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/aes_tag_fifo.sv
// rtl/aes_tag_fifo.sv - order-preserving FIFO of requester tags for in-flight blocks
module aes_tag_fifo
  import aes_sched_pkg::*;
#(
  parameter int TAG_W = 2,
  parameter int DEPTH = 16,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic [TAG_W-1:0] i_tag,
  input  logic             i_pop,
  output logic [TAG_W-1:0] o_head,
  output logic [CNT_W-1:0] o_count,
  output logic             o_full,
  output logic             o_empty
);

  localparam int PTR_W = (clog2(DEPTH) < 1) ? 1 : clog2(DEPTH);

  logic [TAG_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_empty = (r_count == '0);
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;
  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;

  // Explicit wrap so a non-power-of-two depth still works.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_tag;
  end

endmodule

// File: rtl/aes_req_scheduler.sv
// rtl/aes_req_scheduler.sv - round-robin sharing of one pipelined AES core among requesters
module aes_req_scheduler
  import aes_sched_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int TAG_W        = 2,
  parameter int MAX_INFLIGHT = 16,
  parameter int CNT_W        = 5
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         enable_i,
  input  logic [NUM_REQ-1:0]           req_valid_i,
  output logic [NUM_REQ-1:0]           req_ready_o,
  input  logic [NUM_REQ*AES_BLK_W-1:0] req_data_i,
  input  logic [NUM_REQ*AES_BLK_W-1:0] req_key_i,
  input  logic [NUM_REQ-1:0]           req_decrypt_i,
  output logic [NUM_REQ-1:0]           rsp_valid_o,
  output logic [AES_BLK_W-1:0]         rsp_data_o,
  output logic                         load_o,
  output logic                         decrypt_o,
  output logic [AES_BLK_W-1:0]         data_o,
  output logic [AES_BLK_W-1:0]         key_o,
  input  logic [AES_BLK_W-1:0]         data_i,
  input  logic                         ready_i,
  output logic [CNT_W-1:0]             inflight_o,
  output logic                         idle_o,
  output logic                         err_o
);

  sched_state_t     r_state;
  logic [TAG_W-1:0] r_rr;
  logic [TAG_W-1:0] w_win;
  logic [TAG_W:0]   w_idx;
  logic             w_found;
  logic             w_any_valid;
  logic             w_grant_ok;
  logic             w_hs;
  logic             w_pop;
  logic [TAG_W-1:0] w_head;
  logic [CNT_W-1:0] w_count;
  logic             w_full;
  logic             w_empty;

  assign w_any_valid = |req_valid_i;

  // First valid requester at or after the rr pointer, wrapping past NUM_REQ-1.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_idx = {1'b0, r_rr} + (TAG_W + 1)'(i);
      if (w_idx >= (TAG_W + 1)'(NUM_REQ)) w_idx = w_idx - (TAG_W + 1)'(NUM_REQ);
      if (!w_found && req_valid_i[w_idx[TAG_W-1:0]]) begin
        w_found = 1'b1;
        w_win   = w_idx[TAG_W-1:0];
      end
    end
  end

  // IDLE only has a winner when it is about to enter ACTIVE, so it grants alongside ACTIVE.
  assign w_grant_ok = enable_i && !w_full && (r_state != DRAIN);
  assign w_hs       = w_found && w_grant_ok;
  assign w_pop      = ready_i && !w_empty;

  always_comb begin
    req_ready_o = '0;
    if (w_hs) req_ready_o[w_win] = 1'b1;
  end

  aes_tag_fifo #(
    .TAG_W (TAG_W),
    .DEPTH (MAX_INFLIGHT),
    .CNT_W (CNT_W)
  ) u_tag_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_hs),
    .i_tag   (w_win),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign inflight_o = w_count;
  assign idle_o     = (r_state == IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_rr        <= '0;
      load_o      <= 1'b0;
      decrypt_o   <= 1'b0;
      data_o      <= '0;
      key_o       <= '0;
      rsp_valid_o <= '0;
      rsp_data_o  <= '0;
      err_o       <= 1'b0;
    end else begin
      load_o <= w_hs;
      if (w_hs) begin
        data_o    <= req_data_i[32'(w_win) * AES_BLK_W +: AES_BLK_W];
        key_o     <= req_key_i[32'(w_win) * AES_BLK_W +: AES_BLK_W];
        decrypt_o <= req_decrypt_i[w_win];
        r_rr      <= (w_win == TAG_W'(NUM_REQ - 1)) ? '0 : w_win + TAG_W'(1);
      end

      rsp_valid_o <= '0;
      if (w_pop) begin
        rsp_valid_o[w_head] <= 1'b1;
        rsp_data_o          <= data_i;
      end

      if (ready_i && w_empty && !w_hs) err_o <= 1'b1;

      case (r_state)
        IDLE: begin
          if (enable_i && w_any_valid) r_state <= ACTIVE;
        end
        ACTIVE: begin
          if (!enable_i) r_state <= DRAIN;
          else if (w_count == '0 && !w_any_valid && !load_o) r_state <= IDLE;
        end
        DRAIN: begin
          if (enable_i) r_state <= ACTIVE;
          else if (w_count == '0 && !load_o) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_req_scheduler.sv
// tb/tb_aes_req_scheduler.sv - scoreboard bench for aes_req_scheduler
module tb_aes_req_scheduler;

  localparam int NR = 4;
  localparam int CW = 5;

  typedef struct packed {
    logic [127:0] d;
    logic [127:0] k;
    logic         dec;
  } iss_t;

  typedef struct packed {
    logic [3:0]   oh;
    logic [127:0] d;
  } rsp_t;

  logic            clk = 1'b0;
  logic            reset;
  logic            enable_i;
  logic [NR-1:0]   req_valid_i;
  logic [NR-1:0]   req_ready_o;
  logic [NR*128-1:0] req_data_i;
  logic [NR*128-1:0] req_key_i;
  logic [NR-1:0]   req_decrypt_i;
  logic [NR-1:0]   rsp_valid_o;
  logic [127:0]    rsp_data_o;
  logic            load_o;
  logic            decrypt_o;
  logic [127:0]    data_o;
  logic [127:0]    key_o;
  logic [127:0]    data_i;
  logic            ready_i;
  logic [CW-1:0]   inflight_o;
  logic            idle_o;
  logic            err_o;

  int n_checks = 0;
  int n_fail   = 0;

  iss_t exp_iss[$];
  rsp_t exp_rsp[$];
  int   exp_tag[$];

  logic [127:0] tb_data [NR];
  logic [127:0] tb_key  [NR];

  always #5 clk = ~clk;

  aes_req_scheduler #(
    .NUM_REQ      (NR),
    .TAG_W        (2),
    .MAX_INFLIGHT (16),
    .CNT_W        (CW)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .enable_i      (enable_i),
    .req_valid_i   (req_valid_i),
    .req_ready_o   (req_ready_o),
    .req_data_i    (req_data_i),
    .req_key_i     (req_key_i),
    .req_decrypt_i (req_decrypt_i),
    .rsp_valid_o   (rsp_valid_o),
    .rsp_data_o    (rsp_data_o),
    .load_o        (load_o),
    .decrypt_o     (decrypt_o),
    .data_o        (data_o),
    .key_o         (key_o),
    .data_i        (data_i),
    .ready_i       (ready_i),
    .inflight_o    (inflight_o),
    .idle_o        (idle_o),
    .err_o         (err_o)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_bit(input string name, input logic act, input logic exp);
    chk(name, 128'(act), 128'(exp));
  endtask

  task automatic chk_vec(input string name, input logic [NR-1:0] act, input logic [NR-1:0] exp);
    chk(name, 128'(act), 128'(exp));
  endtask

  task automatic chk_cnt(input string name, input logic [CW-1:0] act, input int exp);
    chk(name, 128'(act), 128'(exp));
  endtask

  // Monitor: every load pulse and every response strobe is matched against the scoreboard.
  always @(negedge clk) begin
    iss_t e;
    rsp_t r;
    if (load_o === 1'b1) begin
      if (exp_iss.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_load: got load_o=1 expected no issue");
      end else begin
        e = exp_iss.pop_front();
        chk("load_data", data_o, e.d);
        chk("load_key", key_o, e.k);
        chk_bit("load_decrypt", decrypt_o, e.dec);
      end
    end
    if (rsp_valid_o !== '0) begin
      if (exp_rsp.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_rsp: got rsp_valid_o=%b expected 0000", rsp_valid_o);
      end else begin
        r = exp_rsp.pop_front();
        chk_vec("rsp_route", rsp_valid_o, r.oh);
        chk("rsp_data", rsp_data_o, r.d);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc();
    cyc();
    reset = 1'b0;
  endtask

  task automatic expect_issue(input int g);
    exp_iss.push_back({tb_data[g], tb_key[g], req_decrypt_i[g]});
    exp_tag.push_back(g);
  endtask

  task automatic push_result(input logic [127:0] d);
    int t;
    ready_i = 1'b1;
    data_i  = d;
    if (exp_tag.size() > 0) begin
      t = exp_tag.pop_front();
      exp_rsp.push_back({4'(1 << t), d});
    end
  endtask

  task automatic give_result(input logic [127:0] d);
    push_result(d);
    cyc();
    ready_i = 1'b0;
  endtask

  initial begin
    reset       = 1'b1;
    enable_i    = 1'b0;
    req_valid_i = '0;
    ready_i     = 1'b0;
    data_i      = '0;
    tb_data[0]  = 128'h00112233445566778899aabbccddeeff;
    tb_key[0]   = 128'h000102030405060708090a0b0c0d0e0f;
    tb_data[1]  = 128'h11112222333344445555666677778888;
    tb_key[1]   = 128'hf0e1d2c3b4a5968778695a4b3c2d1e0f;
    tb_data[2]  = 128'hdeadbeef000011112222333344445555;
    tb_key[2]   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    tb_data[3]  = 128'h3243f6a8885a308d313198a2e0370734;
    tb_key[3]   = 128'hcafebabe0123456789abcdeffedcba98;
    for (int k = 0; k < NR; k++) begin
      req_data_i[k*128 +: 128] = tb_data[k];
      req_key_i[k*128 +: 128]  = tb_key[k];
    end
    req_decrypt_i = 4'b1010;

    cyc();
    cyc();
    @(negedge clk);
    chk_bit("rst_load", load_o, 1'b0);
    chk_vec("rst_rsp_valid", rsp_valid_o, 4'b0000);
    chk_cnt("rst_inflight", inflight_o, 0);
    chk_bit("rst_err", err_o, 1'b0);
    chk("rst_data_o", data_o, 128'h0);
    cyc();
    reset = 1'b0;
    @(negedge clk);
    chk_bit("rst_idle", idle_o, 1'b1);
    chk_vec("rst_ready", req_ready_o, 4'b0000);

    // Single request
    cyc();
    enable_i    = 1'b1;
    req_valid_i = 4'b0001;
    @(negedge clk);
    chk_vec("t1_grant", req_ready_o, 4'b0001);
    expect_issue(0);
    cyc();
    req_valid_i = '0;
    @(negedge clk);
    chk_bit("t1_load", load_o, 1'b1);
    chk_cnt("t1_inflight1", inflight_o, 1);
    cyc();
    give_result(128'h69c4e0d86a7b0430d8cdb78070b4c55a);
    @(negedge clk);
    chk_vec("t1_rsp", rsp_valid_o, 4'b0001);
    chk_cnt("t1_inflight0", inflight_o, 0);
    cyc();
    @(negedge clk);
    chk_bit("t1_idle", idle_o, 1'b1);

    // Fairness
    cyc();
    do_reset();
    req_valid_i = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk_vec("t2_grant", req_ready_o, 4'(1 << (i % 4)));
      if (i > 0) chk_bit("t2_load_run", load_o, 1'b1);
      expect_issue(i % 4);
      cyc();
    end
    req_valid_i = '0;
    @(negedge clk);
    chk_bit("t2_load_last", load_o, 1'b1);
    chk_cnt("t2_inflight", inflight_o, 8);
    cyc();
    @(negedge clk);
    chk_bit("t2_load_end", load_o, 1'b0);
    cyc();
    for (int i = 0; i < 8; i++) give_result(128'hc0de0000000000000000000000000000 + 128'(i));
    cyc();
    cyc();
    cyc();

    // Full FIFO
    req_valid_i = 4'b0100;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      chk_vec("t3_grant", req_ready_o, 4'b0100);
      expect_issue(2);
      cyc();
    end
    push_result(128'hf00d0000000000000000000000000000);
    @(negedge clk);
    chk_cnt("t3_inflight_full", inflight_o, 16);
    chk_vec("t3_full_block", req_ready_o, 4'b0000);
    cyc();
    ready_i = 1'b0;
    @(negedge clk);
    chk_cnt("t3_inflight_after_pop", inflight_o, 15);
    chk_vec("t3_regrant", req_ready_o, 4'b0100);
    expect_issue(2);
    cyc();
    req_valid_i = '0;
    for (int i = 0; i < 16; i++) give_result(128'hf00d0000000000000000000000000001 + 128'(i));
    cyc();
    cyc();

    // Simultaneous push and pop
    req_valid_i = 4'b1010;
    for (int i = 0; i < 5; i++) begin
      int g;
      g = (i % 2 == 0) ? 3 : 1;
      @(negedge clk);
      chk_vec("t4_grant", req_ready_o, 4'(1 << g));
      expect_issue(g);
      cyc();
    end
    push_result(128'h5a5a5a5a000000000000000000000000);
    @(negedge clk);
    chk_cnt("t4_inflight_pre", inflight_o, 5);
    chk_vec("t4_grant_pp", req_ready_o, 4'b0010);
    expect_issue(1);
    cyc();
    ready_i     = 1'b0;
    req_valid_i = '0;
    @(negedge clk);
    chk_cnt("t4_inflight_post", inflight_o, 5);
    cyc();
    for (int i = 0; i < 5; i++) give_result(128'h5a5a5a5a000000000000000000000001 + 128'(i));
    cyc();
    cyc();

    // Drain
    req_valid_i = 4'b0001;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk_vec("t5_grant", req_ready_o, 4'b0001);
      expect_issue(0);
      cyc();
    end
    enable_i    = 1'b0;
    req_valid_i = '0;
    @(negedge clk);
    chk_cnt("t5_inflight", inflight_o, 3);
    cyc();
    req_valid_i = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk_vec("t5_nogrant", req_ready_o, 4'b0000);
      give_result(128'hd7a10000000000000000000000000000 + 128'(i));
    end
    @(negedge clk);
    chk_vec("t5_rsp_last", rsp_valid_o, 4'b0001);
    chk_bit("t5_idle_low", idle_o, 1'b0);
    chk_vec("t5_nogrant_end", req_ready_o, 4'b0000);
    cyc();
    @(negedge clk);
    chk_bit("t5_idle_high", idle_o, 1'b1);
    chk_vec("t5_idle_nogrant", req_ready_o, 4'b0000);
    cyc();
    req_valid_i = '0;
    cyc();

    // Error and reset
    @(negedge clk);
    chk_bit("t6_err_pre", err_o, 1'b0);
    cyc();
    ready_i = 1'b1;
    data_i  = 128'hbad0bad0bad0bad0bad0bad0bad0bad0;
    cyc();
    ready_i = 1'b0;
    @(negedge clk);
    chk_bit("t6_err", err_o, 1'b1);
    chk_vec("t6_no_rsp", rsp_valid_o, 4'b0000);
    cyc();
    enable_i    = 1'b1;
    req_valid_i = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk_vec("t6_grant", req_ready_o, 4'(1 << ((i + 1) % 4)));
      expect_issue((i + 1) % 4);
      cyc();
    end
    req_valid_i = '0;
    reset       = 1'b1;
    exp_tag.delete();
    @(negedge clk);
    chk_cnt("t6_inflight_pre_rst", inflight_o, 4);
    cyc();
    @(negedge clk);
    chk_bit("t6_rst_load", load_o, 1'b0);
    chk_vec("t6_rst_rsp", rsp_valid_o, 4'b0000);
    chk_cnt("t6_rst_inflight", inflight_o, 0);
    chk_bit("t6_rst_err", err_o, 1'b0);
    chk("t6_rst_data_o", data_o, 128'h0);
    chk("t6_rst_key_o", key_o, 128'h0);
    chk_bit("t6_rst_decrypt", decrypt_o, 1'b0);
    chk("t6_rst_rsp_data", rsp_data_o, 128'h0);
    chk_vec("t6_rst_ready", req_ready_o, 4'b0000);
    cyc();
    reset = 1'b0;
    @(negedge clk);
    chk_bit("t6_post_idle", idle_o, 1'b1);
    cyc();
    ready_i = 1'b1;
    data_i  = 128'h77777777777777777777777777777777;
    cyc();
    ready_i = 1'b0;
    @(negedge clk);
    chk_bit("t6_stray_err", err_o, 1'b1);
    chk_vec("t6_stray_no_rsp", rsp_valid_o, 4'b0000);
    chk("t6_stray_rsp_data", rsp_data_o, 128'h0);
    cyc();
    cyc();

    chk("iss_queue_empty", 128'(exp_iss.size()), 128'(0));
    chk("rsp_queue_empty", 128'(exp_rsp.size()), 128'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/aes_req_scheduler.md
Name: aes_req_scheduler

Overview:
- Shares one pipelined AES core between NUM_REQ independent requesters.
- Round-robin arbitration; at most one block issued per cycle.
- Requester IDs of in-flight blocks are held in an order-preserving tag FIFO, and each result is routed back to its originator.
- Sits between bus-side clients (Wishbone register front-ends, DMA) and the AES core's load/ready interface.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- TAG_W, 2, requester index width; equals clog2(NUM_REQ).
- MAX_INFLIGHT, 16, tag FIFO depth; must be at least the core pipeline depth.
- CNT_W, 5, in-flight counter width; equals clog2(MAX_INFLIGHT)+1.

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- enable_i  in  1  1 = grant new requests; 0 = drain.
- req_valid_i  in  NUM_REQ  per-requester block valid.
- req_ready_o  out  NUM_REQ  one-hot grant; combinational from valid, state and count.
- req_data_i  in  NUM_REQ*128  flat block bus; requester k occupies [128k+127:128k].
- req_key_i  in  NUM_REQ*128  flat key bus, same packing as req_data_i.
- req_decrypt_i  in  NUM_REQ  1 = decrypt.
- rsp_valid_o  out  NUM_REQ  one-hot result strobe, 1 cycle.
- rsp_data_o  out  128  result block, shared by all requesters.
- load_o  out  1  core load pulse.
- decrypt_o  out  1  core mode.
- data_o  out  128  core input block.
- key_o  out  128  core key.
- data_i  in  128  core result.
- ready_i  in  1  core result-valid pulse, in issue order.
- inflight_o  out  CNT_W  blocks issued but not yet returned.
- idle_o  out  1  state==IDLE.
- err_o  out  1  sticky; ready_i arrived with tag FIFO empty.

Behaviour:
- Reset values: all outputs 0; rr pointer 0; FIFO empty; count 0; state IDLE. A synchronous reset mid-operation discards all tags.
- The core must share the same reset. Stray ready_i pulses after reset set err_o and produce no rsp_valid_o.
- FSM states: IDLE, ACTIVE, DRAIN.
  - IDLE -> ACTIVE: enable_i=1 and any req_valid_i.
  - ACTIVE -> DRAIN: enable_i=0.
  - DRAIN -> IDLE: count==0 and no load_o in the current cycle.
  - DRAIN -> ACTIVE: enable_i=1.
  - ACTIVE -> IDLE: count==0, no valids, no load_o.
- Grant is allowed only when state is ACTIVE (or IDLE with the enter condition true) and count < MAX_INFLIGHT.
- Arbitration:
  - Winner g = first asserted req_valid_i at or after rr pointer, scanning upward with wrap.
  - req_ready_o[g]=1 in the same cycle; handshake = valid & ready.
  - After a handshake, rr pointer = (g+1) mod NUM_REQ. With no handshake, the pointer holds.
- Issue: at the edge ending handshake cycle N:
  - data_o, key_o and decrypt_o register requester g's fields.
  - load_o=1 for exactly cycle N+1, otherwise 0. Back-to-back issues give consecutive load pulses.
  - data_o, key_o and decrypt_o hold their values until the next issue.
  - Tag g is pushed at the same edge.
- Return: ready_i=1 with FIFO nonempty at cycle M:
  - Head tag t is popped.
  - Cycle M+1: rsp_valid_o[t]=1 and rsp_data_o=data_i registered from cycle M.
  - rsp_data_o holds its value otherwise.
  - There is no backpressure; requesters must accept the strobe.
- Count rules:
  - +1 on push, -1 on pop, unchanged on a simultaneous push and pop.
  - A full FIFO with a simultaneous pop still blocks the grant that cycle, because the grant uses the registered count.
- Error: ready_i with FIFO empty (and no push in the same cycle) sets err_o. err_o clears only on reset.
- Pointers wrap modulo MAX_INFLIGHT.

Decomposition:
- Package aes_sched_pkg: AES_BLK_W=128, state enum {IDLE,ACTIVE,DRAIN}, and a clog2 helper function.
- Sub-module aes_tag_fifo: synchronous FIFO of TAG_W-bit entries with push, pop, head, count and full/empty outputs.
- Arbiter, FSM and datapath registers stay in the top-level module.

Test Plan:
- Single request: reset, enable_i=1, req0 valid with data 00112233445566778899aabbccddeeff and key 000102030405060708090a0b0c0d0e0f -> req_ready_o=0001 the same cycle; load_o next cycle with those values; inflight_o=1. Core model returns 69c4e0d86a7b0430d8cdb78070b4c55a -> one cycle later rsp_valid_o=0001 with that data; inflight_o=0; idle_o=1.
- Fairness: all 4 valids held for 8 cycles -> grant order 0,1,2,3,0,1,2,3; 8 consecutive load_o pulses; results return routed 0,1,2,3,0,1,2,3.
- Full: core model withholds ready_i, 16 issues -> inflight_o=16 and req_ready_o=0. One ready_i -> a grant is allowed again the cycle after the pop.
- Simultaneous push and pop at count 5 -> count stays 5; tag order preserved.
- Drain: enable_i=0 with 3 in flight -> no grants; idle_o rises the cycle after the 3rd rsp_valid_o.
- Error and reset: ready_i pulse with nothing in flight -> err_o=1 and no rsp_valid_o. Assert reset with 4 in flight -> all outputs 0 and inflight_o=0.
